variable_table_client: RTL and testbench
========================================

// Module: variable_table_client
// PURPOSE
// - Requester-side controller for one clause evaluator's pair of dual-port variable tables.
// - Evaluation read: accepts a 3-literal clause request and reads the three variable values.
// - Flip: inverts one variable with a read-modify-write and keeps both table copies coherent.
// - Sits between the clause evaluator / flip selector and two slots of the variable table cluster.
// PARAMETERS
// - VARIABLE_ADDRESS_WIDTH  11  width of one variable address
// - TABLE_COPIES            2   tables driven by this client; only 2 is supported
// PORTS
// - clk         in   1      single clock domain
// - rst         in   1      synchronous, active-high reset
// - req_valid   in   1      request valid
// - req_ready   out  1      request accepted when req_valid && req_ready
// - req_op      in   1      0 = evaluation read, 1 = flip
// - req_addr    in   3*W    lit0 [W-1:0], lit1 [2W-1:W], lit2 [3W-1:2W]; flip uses lit0 only
// - rsp_valid   out  1      response valid
// - rsp_ready   in   1      response consumed when rsp_valid && rsp_ready
// - rsp_vals    out  3      read: {v2,v1,v0}; flip: {2'b0,new value}
// - coh_err     out  1      sticky copy-mismatch flag (see CONFIGURATION)
// - en_a,en_b,we_a,we_b  out  2    per-table port controls; bit i = table i
// - addr_a,addr_b        out  2*W  table i address at [i*W +: W]
// - din_a,din_b          out  2    write data
// - dout_a,dout_b        in   2    read data, valid 1 cycle after en
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_vals=0; coh_err=0; all en/we/addr/din=0.
// - All table-side outputs are registered; en/we are high for exactly one cycle per access.
// - FSM: IDLE -> ISSUE -> CAPTURE -> (op=0: RESP | op=1: WRITE -> RESP) -> IDLE.
// - IDLE: req_ready=1. On handshake, latch op and addresses. req_ready=0 in every other state.
// - ISSUE, read: table0 A <- lit0, table0 B <- lit1, table1 A <- lit2; en set, we=0.
// - ISSUE, flip: table0 A <- lit0 read only.
// - CAPTURE: sample dout; read: v0=dout_a[0], v1=dout_b[0], v2=dout_a[1]; flip: nv=~dout_a[0].
// - WRITE (flip only): en_a=we_a=2'b11, addr_a = lit0 on both tables, din_a = {nv,nv}.
// - RESP: rsp_valid=1 and rsp_vals held stable until rsp_ready; next state is IDLE.
// - Latency from accept at cycle T: read rsp_valid at T+3; flip rsp_valid at T+4.
// - Backpressure: rsp_ready low stalls in RESP; no new request is accepted meanwhile.
// - Back-to-back: after the RESP handshake, IDLE is reached next cycle; throughput is 1 request per 4 (read) or 5 (flip) cycles.
// - Duplicate literals (e.g. lit0==lit1) are legal; the same value is returned in each slot.
// - Flip write order is fixed: read value first, then write; both copies are written in the same cycle.
// - Reset in any state, including WRITE, takes effect next edge: en/we=0, no write completes, rsp_valid=0.
// - Inputs change only on handshake; req_addr/req_op are ignored outside IDLE.
// CONFIGURATION
// - Macro VT_COHERENCY_CHECK_EN.
// - Defined, read ops: table1 B also reads lit0 in ISSUE. In CAPTURE, dout_b[1] != dout_a[0] sets coh_err.
//   coh_err stays set until rst; the response is still returned with v0 from table0.
// - Defined, flip ops: table1 A also reads lit0 in ISSUE; a mismatch sets coh_err the same way.
// - Not defined: table1 port B is tied off (en_b[1]=we_b[1]=0, addr/din=0) and coh_err is constant 0.
// - Port list is identical in both builds.
// TESTING
// - Preload v5=1, v9=0, v12=1; read {12,9,5} -> at T+3 rsp_vals=3'b101; en pulses exactly once in ISSUE.
// - Flip v9 (=0), W=11 -> WRITE cycle we_a=2'b11, addr_a={9,9}, din_a=2'b11; rsp_vals=3'b001 at T+4.
//   A following read returns v9=1 from both tables.
// - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_vals stable, req_ready=0, no table access; release -> IDLE next cycle.
// - Assert rst during flip WRITE cycle -> no write on the following edge; outputs at reset values.
//   Table value is unchanged, or is the new value in both copies, never split.
// - Read {7,7,7} with v7=1 -> rsp_vals=3'b111.
// - VT_COHERENCY_CHECK_EN: corrupt table1 v3 to differ from table0; read lit0=3 -> coh_err=1, sticky until rst.
//   Undefined build: coh_err stays 0 and en_b[1] is never asserted.

Source files
------------

// File: rtl/variable_table_client_if.sv
// -----------------------------------------------------------------------------
// variable_table_client_if
//
// Groups every non-clock signal of variable_table_client into one bundle.
//
// Request / response side (clause evaluator and flip selector):
//   req_valid, req_ready, req_op, req_addr[3*W-1:0]
//   rsp_valid, rsp_ready, rsp_vals[2:0], coh_err
// Table side (two slots of the variable table cluster, bit i = table i):
//   en_a, en_b, we_a, we_b   [N-1:0]
//   addr_a, addr_b           [N*W-1:0]  table i address at [i*W +: W]
//   din_a, din_b, dout_a, dout_b [N-1:0]
//
// Modports:
//   slave  - the client itself: it is the target of the request bus and
//            drives the table port controls.
//   master - the surrounding environment: requester plus table cluster.
// -----------------------------------------------------------------------------
interface variable_table_client_if #(
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int TABLE_COPIES           = 2
);
  localparam int W = VARIABLE_ADDRESS_WIDTH;
  localparam int N = TABLE_COPIES;

  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [3*W-1:0]   req_addr;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_vals;
  logic             coh_err;

  logic [N-1:0]     en_a;
  logic [N-1:0]     en_b;
  logic [N-1:0]     we_a;
  logic [N-1:0]     we_b;
  logic [N*W-1:0]   addr_a;
  logic [N*W-1:0]   addr_b;
  logic [N-1:0]     din_a;
  logic [N-1:0]     din_b;
  logic [N-1:0]     dout_a;
  logic [N-1:0]     dout_b;

  modport slave (
    input  req_valid, req_op, req_addr, rsp_ready, dout_a, dout_b,
    output req_ready, rsp_valid, rsp_vals, coh_err,
           en_a, en_b, we_a, we_b, addr_a, addr_b, din_a, din_b
  );

  modport master (
    output req_valid, req_op, req_addr, rsp_ready, dout_a, dout_b,
    input  req_ready, rsp_valid, rsp_vals, coh_err,
           en_a, en_b, we_a, we_b, addr_a, addr_b, din_a, din_b
  );
endinterface

// File: rtl/variable_table_client.sv
// -----------------------------------------------------------------------------
// variable_table_client
//
// Requester-side controller for one clause evaluator's pair of dual-port
// variable tables (two copies holding the same assignment).
//   * op 0 (evaluation read): reads the three literals of a clause,
//     lit0 and lit2 through port A of table 0 / table 1, lit1 through port B
//     of table 0, and returns {v2,v1,v0}.
//   * op 1 (flip): reads lit0, inverts it and writes the new value into both
//     copies in the same cycle, returning {2'b0,new value}.
//
// Ports:
//   clk             single clock
//   rst             synchronous, active-high reset
//   bus (slave)     request/response handshake and both tables' port controls,
//                   see variable_table_client_if
//
// Sequence: IDLE -> ISSUE -> CAPTURE -> (read: RESP | flip: WRITE -> RESP).
// Table-side outputs are registered, so the access belonging to a state is
// computed on the transition into that state. Read data arrives one cycle
// after en, i.e. in CAPTURE. Latency from acceptance at cycle T: read
// response at T+3, flip response at T+4.
//
// Build option VT_COHERENCY_CHECK_EN:
//   defined   - table 1 additionally reads lit0 (port B for reads, port A for
//               flips) and any difference from table 0 sets the sticky coh_err.
//   undefined - table 1 port B is tied off and coh_err is constant 0.
// The port list is identical in both builds.
// -----------------------------------------------------------------------------
module variable_table_client #(
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int TABLE_COPIES           = 2   // only 2 is supported
) (
  input  logic                    clk,
  input  logic                    rst,
  variable_table_client_if.slave  bus
);
  localparam int W = VARIABLE_ADDRESS_WIDTH;
  localparam int N = TABLE_COPIES;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  // Control state and latched request. Only lit0 is needed after ISSUE
  // (flip write-back), lit1/lit2 are consumed on the way into ISSUE.
  logic [2:0]     state_q, state_d;
  logic           op_q, op_d;
  logic [W-1:0]   lit0_q, lit0_d;

  // Registered table-side outputs.
  logic [N-1:0]   en_a_q, en_a_d;
  logic [N-1:0]   en_b_q, en_b_d;
  logic [N-1:0]   we_a_q, we_a_d;
  logic [N*W-1:0] addr_a_q, addr_a_d;
  logic [N*W-1:0] addr_b_q, addr_b_d;
  logic [N-1:0]   din_a_q, din_a_d;

  // Response data, held from CAPTURE until the response handshake.
  logic [2:0]     rsp_vals_q, rsp_vals_d;

`ifdef VT_COHERENCY_CHECK_EN
  logic           coh_err_q, coh_err_d;
  logic           mismatch;
`endif

  // Request literal fields, used directly while leaving IDLE.
  logic [W-1:0]   req_lit0;
  logic [W-1:0]   req_lit1;
  logic [W-1:0]   req_lit2;
  logic           new_val;

  assign req_lit0 = bus.req_addr[0   +: W];
  assign req_lit1 = bus.req_addr[W   +: W];
  assign req_lit2 = bus.req_addr[2*W +: W];

  // Flip value: always derived from table 0, the reference copy.
  assign new_val  = ~bus.dout_a[0];

  always_comb begin
    // NOTE: every next-state variable gets a default before the case, so no
    // path through the decode leaves one unassigned and infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    lit0_d     = lit0_q;
    rsp_vals_d = rsp_vals_q;
    // Table controls default to idle: every access is a one-cycle pulse and
    // address/data return to zero between accesses.
    en_a_d     = '0;
    en_b_d     = '0;
    we_a_d     = '0;
    addr_a_d   = '0;
    addr_b_d   = '0;
    din_a_d    = '0;
`ifdef VT_COHERENCY_CHECK_EN
    coh_err_d  = coh_err_q;
    mismatch   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          lit0_d  = req_lit0;
          state_d = ST_ISSUE;
          if (!bus.req_op) begin
            // Evaluation read: three independent single-bit reads.
            en_a_d[0]          = 1'b1;
            addr_a_d[0 +: W]   = req_lit0;
            en_b_d[0]          = 1'b1;
            addr_b_d[0 +: W]   = req_lit1;
            en_a_d[1]          = 1'b1;
            addr_a_d[W +: W]   = req_lit2;
`ifdef VT_COHERENCY_CHECK_EN
            // Spare port of table 1 shadows lit0 for the copy comparison.
            en_b_d[1]          = 1'b1;
            addr_b_d[W +: W]   = req_lit0;
`endif
          end else begin
            // Flip: read-modify-write starts with a read of lit0.
            en_a_d[0]          = 1'b1;
            addr_a_d[0 +: W]   = req_lit0;
`ifdef VT_COHERENCY_CHECK_EN
            en_a_d[1]          = 1'b1;
            addr_a_d[W +: W]   = req_lit0;
`endif
          end
        end
      end

      ST_ISSUE: begin
        // Access is on the table ports this cycle; data returns next cycle.
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        if (op_q) begin
          rsp_vals_d        = {2'b00, new_val};
          // Both copies are written in the same cycle so they never diverge.
          en_a_d            = '1;
          we_a_d            = '1;
          addr_a_d[0 +: W]  = lit0_q;
          addr_a_d[W +: W]  = lit0_q;
          din_a_d           = {N{new_val}};
          state_d           = ST_WRITE;
`ifdef VT_COHERENCY_CHECK_EN
          mismatch          = bus.dout_a[1] != bus.dout_a[0];
`endif
        end else begin
          rsp_vals_d        = {bus.dout_a[1], bus.dout_b[0], bus.dout_a[0]};
          state_d           = ST_RESP;
`ifdef VT_COHERENCY_CHECK_EN
          mismatch          = bus.dout_b[1] != bus.dout_a[0];
`endif
        end
`ifdef VT_COHERENCY_CHECK_EN
        // Sticky: cleared only by reset. The response itself is unaffected.
        coh_err_d = coh_err_q | mismatch;
`endif
      end

      ST_WRITE: begin
        // Write pulse is on the ports this cycle.
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 1'b0;
      lit0_q     <= '0;
      en_a_q     <= '0;
      en_b_q     <= '0;
      we_a_q     <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      din_a_q    <= '0;
      rsp_vals_q <= '0;
`ifdef VT_COHERENCY_CHECK_EN
      coh_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lit0_q     <= lit0_d;
      en_a_q     <= en_a_d;
      en_b_q     <= en_b_d;
      we_a_q     <= we_a_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      din_a_q    <= din_a_d;
      rsp_vals_q <= rsp_vals_d;
`ifdef VT_COHERENCY_CHECK_EN
      coh_err_q  <= coh_err_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_vals  = rsp_vals_q;

  assign bus.en_a      = en_a_q;
  assign bus.en_b      = en_b_q;
  assign bus.we_a      = we_a_q;
  assign bus.addr_a    = addr_a_q;
  assign bus.addr_b    = addr_b_q;
  assign bus.din_a     = din_a_q;
  // Port B is read-only in both builds.
  assign bus.we_b      = '0;
  assign bus.din_b     = '0;

`ifdef VT_COHERENCY_CHECK_EN
  assign bus.coh_err   = coh_err_q;
`else
  assign bus.coh_err   = 1'b0;
`endif

endmodule

// File: tb/tb_variable_table_client.sv
`timescale 1ns/1ps
module tb_variable_table_client;
  localparam int W     = 11;
  localparam int N     = 2;
  localparam int DEPTH = 1 << W;

`ifdef VT_COHERENCY_CHECK_EN
  localparam bit COH = 1'b1;
`else
  localparam bit COH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  variable_table_client_if #(.VARIABLE_ADDRESS_WIDTH(W), .TABLE_COPIES(N)) bus ();

  variable_table_client #(
    .VARIABLE_ADDRESS_WIDTH(W),
    .TABLE_COPIES(N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------------
  // Environment: two dual-port single-bit tables, read-first, 1-cycle read
  // latency, plus a backdoor write port used for preloading / corruption.
  // ---------------------------------------------------------------------------
  logic         t0 [DEPTH];
  logic         t1 [DEPTH];
  logic         bd_en = 1'b0;
  logic [W-1:0] bd_addr = '0;
  logic         bd_v0 = 1'b0;
  logic         bd_v1 = 1'b0;

  always @(posedge clk) begin
    if (bus.en_a[0]) begin
      bus.dout_a[0] <= t0[bus.addr_a[0 +: W]];
      if (bus.we_a[0]) t0[bus.addr_a[0 +: W]] <= bus.din_a[0];
    end
    if (bus.en_a[1]) begin
      bus.dout_a[1] <= t1[bus.addr_a[W +: W]];
      if (bus.we_a[1]) t1[bus.addr_a[W +: W]] <= bus.din_a[1];
    end
    if (bus.en_b[0]) begin
      bus.dout_b[0] <= t0[bus.addr_b[0 +: W]];
      if (bus.we_b[0]) t0[bus.addr_b[0 +: W]] <= bus.din_b[0];
    end
    if (bus.en_b[1]) begin
      bus.dout_b[1] <= t1[bus.addr_b[W +: W]];
      if (bus.we_b[1]) t1[bus.addr_b[W +: W]] <= bus.din_b[1];
    end
    if (bd_en) begin
      t0[bd_addr] <= bd_v0;
      t1[bd_addr] <= bd_v1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: the logical variable assignment plus the sticky flag.
  // ---------------------------------------------------------------------------
  bit model [DEPTH];
  bit coh_sticky = 1'b0;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [W-1:0] a, input logic v0, input logic v1);
    bd_en   = 1'b1;
    bd_addr = a;
    bd_v0   = v0;
    bd_v1   = v1;
    @(posedge clk); #1;
    bd_en   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_vals"},  bus.rsp_vals,  0);
    check({tag, "_coh_err"},   bus.coh_err,   0);
    check({tag, "_en_we"},     {bus.en_a, bus.en_b, bus.we_a, bus.we_b}, 0);
    check({tag, "_addr"},      {bus.addr_a, bus.addr_b}, 0);
    check({tag, "_din"},       {bus.din_a, bus.din_b}, 0);
  endtask

  // One transaction. stall = extra cycles rsp_ready stays low in RESP.
  // rst_in_write asserts reset during the flip WRITE cycle.
  task automatic run(input logic op, input logic [W-1:0] l0, input logic [W-1:0] l1,
                     input logic [W-1:0] l2, input int stall, input bit rst_in_write);
    logic [2:0]   exp_vals;
    logic         nv;
    logic         old_v;
    logic [N-1:0] exp_en_a;
    logic [N-1:0] exp_en_b;
    int           waitc;

    old_v    = model[l0];
    nv       = ~model[l0];
    exp_vals = op ? {2'b00, nv} : {model[l2], model[l1], model[l0]};
    exp_en_a = op ? {COH, 1'b1} : 2'b11;
    exp_en_b = op ? 2'b00 : {COH, 1'b1};
    // Copy mismatch is only observable when the check is built in.
    coh_sticky = coh_sticky | (COH & (t0[l0] !== t1[l0]));

    waitc = 0;
    while (bus.req_ready !== 1'b1 && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("idle_req_ready", bus.req_ready, 1);

    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = {l2, l1, l0};
    @(posedge clk); #1;
    // Junk on the request fields after acceptance must not matter.
    bus.req_valid = 1'b0;
    bus.req_op    = 1'($urandom);
    bus.req_addr  = (3*W)'({$urandom, $urandom});

    // T+1: ISSUE, single access pulse.
    @(negedge clk);
    check("issue_en_a", bus.en_a, exp_en_a);
    check("issue_en_b", bus.en_b, exp_en_b);
    check("issue_we",   {bus.we_a, bus.we_b}, 0);
    check("issue_busy", {bus.req_ready, bus.rsp_valid}, 0);
    check("issue_addr_a0", bus.addr_a[0 +: W], l0);
    if (exp_en_a[1]) check("issue_addr_a1", bus.addr_a[W +: W], op ? l0 : l2);
    if (exp_en_b[0]) check("issue_addr_b0", bus.addr_b[0 +: W], l1);
    if (exp_en_b[1]) check("issue_addr_b1", bus.addr_b[W +: W], l0);

    // T+2: CAPTURE, no access.
    @(negedge clk);
    check("capture_idle_ports", {bus.en_a, bus.en_b, bus.we_a, bus.we_b}, 0);
    check("capture_busy", {bus.req_ready, bus.rsp_valid}, 0);

    if (op) begin
      // T+3: WRITE, both copies in the same cycle.
      @(negedge clk);
      check("write_en_we", {bus.en_a, bus.we_a, bus.en_b, bus.we_b}, {2'b11, 2'b11, 4'b0000});
      check("write_addr",  bus.addr_a, {l0, l0});
      check("write_din",   bus.din_a,  {nv, nv});
      check("write_busy",  {bus.req_ready, bus.rsp_valid}, 0);
      if (rst_in_write) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_in_write");
        rst = 1'b0;
        coh_sticky = 1'b0;
        check("rst_no_split", t0[l0], t1[l0]);
        check("rst_old_or_new", (t0[l0] === old_v) || (t0[l0] === nv), 1);
        model[l0] = t0[l0];
        @(posedge clk); #1;
        check("rst_no_write_after", t0[l0], model[l0]);
        return;
      end
    end

    // RESP.
    @(negedge clk);
    check("resp_valid", bus.rsp_valid, 1);
    check("resp_vals",  bus.rsp_vals,  exp_vals);
    check("resp_ready_low", bus.req_ready, 0);
    check("resp_coh_err", bus.coh_err, coh_sticky);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_vals",  bus.rsp_vals,  exp_vals);
      check("stall_no_accept", bus.req_ready, 0);
      check("stall_no_access", {bus.en_a, bus.en_b, bus.we_a, bus.we_b}, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("back_to_idle", {bus.req_ready, bus.rsp_valid}, 2'b10);

    if (op) begin
      model[l0] = nv;
      check("flip_t0", t0[l0], nv);
      check("flip_t1", t1[l0], nv);
    end
  endtask

  initial begin
    logic v;
    logic [W-1:0] a0, a1, a2;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload both copies with the same random assignment.
    for (int a = 0; a < DEPTH; a++) begin
      v = 1'($urandom);
      model[a] = v;
      poke(W'(a), v, v);
    end
    poke(11'd5, 1'b1, 1'b1);  model[5]  = 1'b1;
    poke(11'd9, 1'b0, 1'b0);  model[9]  = 1'b0;
    poke(11'd12, 1'b1, 1'b1); model[12] = 1'b1;
    poke(11'd7, 1'b1, 1'b1);  model[7]  = 1'b1;

    // Directed cases.
    run(1'b0, 11'd5, 11'd9, 11'd12, 0, 1'b0);   // {v12,v9,v5} = 101
    run(1'b1, 11'd9, 11'd0, 11'd0, 0, 1'b0);    // v9 0 -> 1, rsp 001
    run(1'b0, 11'd9, 11'd9, 11'd9, 0, 1'b0);    // v9 now 1 in every slot
    run(1'b0, 11'd7, 11'd7, 11'd7, 0, 1'b0);    // duplicate literals, 111
    run(1'b0, 11'd5, 11'd12, 11'd9, 5, 1'b0);   // 5 cycles of backpressure
    run(1'b1, 11'd2047, 11'd0, 11'd0, 2, 1'b0); // top address flip
    run(1'b0, 11'd2047, 11'd0, 11'd2047, 0, 1'b0);
    run(1'b1, 11'd12, 11'd0, 11'd0, 0, 1'b1);   // reset during WRITE
    run(1'b0, 11'd12, 11'd12, 11'd12, 0, 1'b0);

    // Copy corruption at v3: only the checking build flags it, sticky.
    poke(11'd3, model[3], ~model[3]);
    run(1'b0, 11'd3, 11'd9, 11'd5, 0, 1'b0);
    run(1'b0, 11'd5, 11'd7, 11'd9, 1, 1'b0);
    check("coh_sticky_idle", bus.coh_err, COH);
    poke(11'd3, model[3], model[3]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    coh_sticky = 1'b0;
    @(negedge clk);
    check_reset_outputs("coh_reset");

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      a0 = W'($urandom_range(0, DEPTH - 1));
      a1 = W'($urandom_range(0, DEPTH - 1));
      a2 = W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 5) == 0) a1 = a0;
      if ($urandom_range(0, 7) == 0) a0 = '1;
      run(1'($urandom_range(0, 1)), a0, a1, a2, $urandom_range(0, 3), 1'b0);
    end
    check("final_coh_err", bus.coh_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends by itself.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
